// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and load paths for the register-file write
// port, with a busy-mask scoreboard for outstanding destination registers.
module regfile_wb_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [63:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [63:0] mem_data,
    output logic        mem_ready,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [63:0] Write_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    input  logic [4:0]  query_reg_1,
    input  logic [4:0]  query_reg_2,
    output logic        hazard_1,
    output logic        hazard_2,
    output logic [5:0]  busy_count
);

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 6;
    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e              last_grant;
    logic                contended;
    logic                alu_acc;
    logic                mem_acc;
    logic                wr_acc;
    logic [REG_W-1:0]    wr_reg;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // Round-robin arbitration: on contention the loser of the last contended cycle wins.
    always_comb begin
        contended = alu_valid && mem_valid;
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!reset) begin
            alu_ready = !contended || (last_grant == GRANT_MEM);
            mem_ready = !contended || (last_grant == GRANT_ALU);
        end
        alu_acc = alu_valid && alu_ready;
        mem_acc = mem_valid && mem_ready;
        wr_acc  = alu_acc || mem_acc;
        wr_reg  = mem_acc ? mem_reg  : alu_reg;
        wr_data = mem_acc ? mem_data : alu_data;
    end

    // Next busy mask (issue applied after clear so issue wins) and its population count.
    always_comb begin
        busy_nxt = busy;
        if (wr_acc && (wr_reg != XZR)) begin
            busy_nxt[wr_reg] = 1'b0;
        end
        if (issue_valid && (issue_reg != XZR)) begin
            busy_nxt[issue_reg] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    // Operand hazard lookup; XZR is never pending.
    always_comb begin
        hazard_1 = (query_reg_1 != XZR) && busy[query_reg_1];
        hazard_2 = (query_reg_2 != XZR) && busy[query_reg_2];
    end

    // Registered write port, grant history and scoreboard state.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant     <= GRANT_ALU;
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
            busy           <= '0;
            busy_count     <= '0;
        end else begin
            if (contended) begin
                last_grant <= mem_acc ? GRANT_MEM : GRANT_ALU;
            end
            RegWrite <= wr_acc && (wr_reg != XZR);
            if (wr_acc) begin
                Write_register <= wr_reg;
                Write_data     <= wr_data;
            end
            busy       <= busy_nxt;
            busy_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with an abstract reference model.
module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [63:0] Write_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  query_reg_1;
    logic [4:0]  query_reg_2;
    logic        hazard_1;
    logic        hazard_2;
    logic [5:0]  busy_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: who took the last contested slot, pending set, port view.
    bit          m_last_mem = 1'b0;
    bit          m_busy [32];
    bit          m_we = 1'b0;
    logic [4:0]  m_wreg = '0;
    logic [63:0] m_wdata = '0;
    int          m_cnt = 0;

    regfile_wb_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_reg        (mem_reg),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .issue_valid    (issue_valid),
        .issue_reg      (issue_reg),
        .query_reg_1    (query_reg_1),
        .query_reg_2    (query_reg_2),
        .hazard_1       (hazard_1),
        .hazard_2       (hazard_2),
        .busy_count     (busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Model: apply the transfer and scoreboard rules once per rising edge.
    always @(posedge clock) begin
        bit a_win;
        bit m_win;
        bit take;
        logic [4:0]  r;
        logic [63:0] d;
        if (reset) begin
            m_last_mem = 1'b0;
            m_we       = 1'b0;
            m_wreg     = '0;
            m_wdata    = '0;
            foreach (m_busy[k]) m_busy[k] = 1'b0;
        end else begin
            if (alu_valid && mem_valid) begin
                m_win = !m_last_mem;
                a_win = m_last_mem;
                m_last_mem = m_win;
            end else begin
                a_win = alu_valid;
                m_win = mem_valid;
            end
            take = a_win || m_win;
            r = m_win ? mem_reg : alu_reg;
            d = m_win ? mem_data : alu_data;
            m_we = take && (r != 5'd31);
            if (take) begin
                m_wreg  = r;
                m_wdata = d;
                if (r != 5'd31) m_busy[r] = 1'b0;
            end
            if (issue_valid && issue_reg != 5'd31) m_busy[issue_reg] = 1'b1;
        end
        m_cnt = 0;
        foreach (m_busy[k]) m_cnt += int'(m_busy[k]);
    end

    // Compare DUT against model mid-cycle.
    always @(negedge clock) begin
        check("RegWrite", 64'(RegWrite), 64'(m_we));
        check("Write_register", 64'(Write_register), 64'(m_wreg));
        check("Write_data", Write_data, m_wdata);
        check("busy_count", 64'(busy_count), 64'(m_cnt));
        check("hazard_1", 64'(hazard_1), 64'(query_reg_1 != 5'd31 && m_busy[query_reg_1]));
        check("hazard_2", 64'(hazard_2), 64'(query_reg_2 != 5'd31 && m_busy[query_reg_2]));
        if (reset) begin
            check("alu_ready_rst", 64'(alu_ready), 64'd0);
            check("mem_ready_rst", 64'(mem_ready), 64'd0);
        end else begin
            if (alu_valid)
                check("alu_ready", 64'(alu_ready), 64'(!mem_valid || m_last_mem));
            if (mem_valid)
                check("mem_ready", 64'(mem_ready), 64'(!alu_valid || !m_last_mem));
            if (!alu_valid && !mem_valid) begin
                check("alu_ready_idle", 64'(alu_ready), 64'd1);
                check("mem_ready_idle", 64'(mem_ready), 64'd1);
            end
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        issue_valid = 1'b0; issue_reg = '0;
        query_reg_1 = '0; query_reg_2 = '0;
        step();
        step();
        check("rst_RegWrite", 64'(RegWrite), 64'd0);
        check("rst_busy_count", 64'(busy_count), 64'd0);
        check("rst_Write_data", Write_data, 64'd0);
        reset = 1'b0;
        #1;
        check("idle_alu_ready", 64'(alu_ready), 64'd1);
        check("idle_mem_ready", 64'(mem_ready), 64'd1);

        // Single ALU write
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 64'hDEAD;
        step();
        alu_valid = 1'b0;
        check("alu_wr_we", 64'(RegWrite), 64'd1);
        check("alu_wr_reg", 64'(Write_register), 64'd5);
        check("alu_wr_data", Write_data, 64'hDEAD);
        step();
        check("alu_wr_pulse", 64'(RegWrite), 64'd0);
        check("alu_wr_hold", Write_data, 64'hDEAD);

        // Contention: mem, alu, mem
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 64'h22;
        #1;
        check("cont_mem_first", 64'(mem_ready), 64'd1);
        check("cont_alu_blocked", 64'(alu_ready), 64'd0);
        step();
        check("cont1_reg", 64'(Write_register), 64'd2);
        step();
        check("cont2_reg", 64'(Write_register), 64'd1);
        check("cont2_data", Write_data, 64'h11);
        step();
        check("cont3_reg", 64'(Write_register), 64'd2);
        check("cont3_we", 64'(RegWrite), 64'd1);
        alu_valid = 1'b0; mem_valid = 1'b0;

        // XZR write and issue
        mem_valid = 1'b1; mem_reg = 5'd31; mem_data = 64'h99;
        #1;
        check("xzr_mem_ready", 64'(mem_ready), 64'd1);
        step();
        mem_valid = 1'b0;
        check("xzr_no_we", 64'(RegWrite), 64'd0);
        issue_valid = 1'b1; issue_reg = 5'd31; query_reg_1 = 5'd31;
        step();
        check("xzr_cnt", 64'(busy_count), 64'd0);
        check("xzr_hazard", 64'(hazard_1), 64'd0);

        // Scoreboard set/clear
        issue_reg = 5'd3; step();
        issue_reg = 5'd7; step();
        issue_valid = 1'b0; query_reg_1 = 5'd3;
        #1;
        check("sb_cnt2", 64'(busy_count), 64'd2);
        check("sb_hazard3", 64'(hazard_1), 64'd1);
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 64'h33;
        step();
        alu_valid = 1'b0;
        check("sb_cnt1", 64'(busy_count), 64'd1);
        check("sb_hazard3_clr", 64'(hazard_1), 64'd0);

        // Simultaneous issue and write to a busy register
        issue_valid = 1'b1; issue_reg = 5'd4; step();
        alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 64'h44; query_reg_2 = 5'd4;
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        check("sim_cnt", 64'(busy_count), 64'd2);
        check("sim_hazard4", 64'(hazard_2), 64'd1);
        check("sim_we", 64'(RegWrite), 64'd1);

        // Re-issue of busy register, then write to idle register
        issue_valid = 1'b1; issue_reg = 5'd7; step();
        issue_valid = 1'b0;
        check("reissue_cnt", 64'(busy_count), 64'd2);
        alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 64'h9999; step();
        alu_valid = 1'b0;
        check("idle_wr_we", 64'(RegWrite), 64'd1);
        check("idle_wr_cnt", 64'(busy_count), 64'd2);

        // Reset mid-operation
        alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 64'hAB;
        step();
        check("pre_rst_we", 64'(RegWrite), 64'd1);
        reset = 1'b1; mem_valid = 1'b1; issue_valid = 1'b1; issue_reg = 5'd12;
        #1;
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        step();
        check("mid_rst_we", 64'(RegWrite), 64'd0);
        check("mid_rst_cnt", 64'(busy_count), 64'd0);
        check("mid_rst_reg", 64'(Write_register), 64'd0);
        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        step();

        // First contention after reset goes to mem
        alu_valid = 1'b1; alu_reg = 5'd13; mem_valid = 1'b1; mem_reg = 5'd14;
        step();
        check("post_rst_cont", 64'(Write_register), 64'd14);

        // Mixed sweep checked by the model
        for (int i = 0; i < 16; i++) begin
            alu_valid   = i[0];
            mem_valid   = i[1];
            issue_valid = i[2];
            alu_reg     = 5'(i + 16);
            mem_reg     = 5'(i);
            alu_data    = 64'(i * 3 + 1);
            mem_data    = 64'(i * 5 + 2);
            issue_reg   = 5'(i + 20);
            query_reg_1 = 5'(i + 16);
            query_reg_2 = 5'(i + 20);
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        step();
        step();
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
